sdram_init_seq: RTL and testbench
=================================

SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

Interface
REQ-001 Parameter POWERUP_CYCLES, default 10000, meaning NOP cycles after reset release before first PRECHARGE.
REQ-002 Parameter TRP, default 2, meaning cycles from PRECHARGE to next command.
REQ-003 Parameter TRFC, default 7, meaning cycles from AUTO REFRESH to next command.
REQ-004 Parameter TMRD, default 2, meaning cycles from LOAD MODE to init_done.
REQ-005 Parameter NUM_REFRESH, default 8, meaning number of AUTO REFRESH commands, range 2..15.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 cfg_mode_reg  in  13  mode-register value; [2:0] burst length, [3] burst type, [6:4] CAS latency.
REQ-009 reinit  in  1  single-cycle request to rerun initialization from PRECHARGE.
REQ-010 sdr_cke  out  1  clock enable.
REQ-011 sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  out  1 each  SDRAM command, active low.
REQ-012 sdr_addr  out  13  address bus.
REQ-013 sdr_ba  out  2  bank address.
REQ-014 init_done  out  1  initialization complete; controller may issue traffic.
REQ-015 cfg_err  out  1  sticky flag for illegal CAS latency.

Function
REQ-016 Commands {cs_n,ras_n,cas_n,we_n}: DESELECT=1111, NOP=0111, PRECHARGE=0010, AUTO_REFRESH=0001, LOAD_MODE=0000.
REQ-017 States: PWR_WAIT, PRECHARGE, TRP_WAIT, AREF, TRFC_WAIT, LMR, TMRD_WAIT, DONE; each command state lasts exactly one cycle.
REQ-018 First cycle after rst deasserts: state PWR_WAIT, sdr_cke=1, NOP driven for exactly POWERUP_CYCLES cycles.
REQ-019 PRECHARGE drives sdr_addr[10]=1 (all banks) and all other sdr_addr and sdr_ba bits 0.
REQ-020 Command-to-command spacing: a command at cycle t is followed by the next command at exactly t+TRP (after PRECHARGE) or t+TRFC (after AUTO_REFRESH); NOP drives all gap cycles.
REQ-021 Exactly NUM_REFRESH AUTO_REFRESH commands are issued; a 4-bit refresh counter decrements on each one; LMR follows the last TRFC gap.
REQ-022 LMR drives sdr_ba=0 and sdr_addr=cfg_mode_reg, sampled in the LMR cycle.
REQ-023 Legal CAS latency is [6:4] = 3'b010 or 3'b011; any other value issues LOAD_MODE with [6:4] forced to 3'b011 and sets cfg_err=1 until rst.
REQ-024 init_done rises at LMR cycle + TMRD and stays high in DONE; DONE drives NOP with sdr_cke=1.
REQ-025 reinit high in DONE: init_done=0 next cycle, which is a PRECHARGE; power-up wait is skipped; cfg_err is retained.
REQ-026 reinit outside DONE is ignored and does not alter any counter.
REQ-027 A single 16-bit wait down-counter serves all waits; it loads (N-1) on state entry and the state exits when the count reaches 0.

Reset
REQ-028 While rst=1: DESELECT (1111), sdr_cke=0, sdr_addr=0, sdr_ba=0, init_done=0, cfg_err=0, counters cleared.
REQ-029 rst asserted in any state, mid-sequence included, aborts the sequence; after release the sequence restarts from PWR_WAIT with the full POWERUP_CYCLES wait.
REQ-030 rst and reinit asserted together: rst wins.

Structure
REQ-031 Package sdram_init_pkg holds the state enum, the 4-bit command encodings and the default timing constants.
REQ-032 The wait counter is the one sub-module, sdram_wait_cnt, with load, value and zero flag; all remaining logic stays flat.

Verification
REQ-033 rst high for 3 cycles, then low -> outputs 1111/cke=0 during reset; NOP on cycles 1..10000 after release; PRECHARGE with addr[10]=1 on cycle 10001.
REQ-034 Full sequence, defaults -> PRECHARGE, AREF 2 cycles later, 8 AREFs spaced 7 cycles apart, LMR 7 cycles after the last AREF, init_done 2 cycles after LMR.
REQ-035 cfg_mode_reg=13'h037 (full page, CL=3) -> LMR drives sdr_addr=13'h037 and cfg_err=0; cfg_mode_reg=13'h047 (CL=4) -> sdr_addr=13'h037 and cfg_err=1.
REQ-036 reinit pulse in DONE -> init_done low next cycle together with PRECHARGE; full precharge/refresh/LMR sequence repeats with no power-up wait.
REQ-037 rst pulsed during the 4th TRFC_WAIT -> DESELECT during rst; 10000 NOP cycles after release; refresh count restarts at 8.
REQ-038 reinit held high during PWR_WAIT, and reinit with rst in the same cycle -> no effect on sequence timing; reset behaviour matches REQ-028.

Source files
------------

// File: rtl/sdram_init_pkg.sv
// Shared types and constants for the SDRAM power-up initialization sequencer.
package sdram_init_pkg;

  // Sequencer states; every command state lasts exactly one cycle.
  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_PRECHARGE,
    ST_TRP_WAIT,
    ST_AREF,
    ST_TRFC_WAIT,
    ST_LMR,
    ST_TMRD_WAIT,
    ST_DONE
  } state_e;

  // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESELECT  = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_LMR       = 4'b0000;

  // Default timing, in clk cycles
  localparam int DEF_POWERUP_CYCLES = 10000;
  localparam int DEF_TRP            = 2;
  localparam int DEF_TRFC           = 7;
  localparam int DEF_TMRD           = 2;
  localparam int DEF_NUM_REFRESH    = 8;

  localparam logic [2:0] CL_SAFE = 3'b011;

  // Only CL=2 and CL=3 are supported by the attached device family.
  function automatic logic cl_legal(input logic [2:0] cl);
    return (cl == 3'b010) || (cl == 3'b011);
  endfunction

  // Mode word actually loaded: an unsupported CAS latency is replaced by CL=3.
  function automatic logic [12:0] fix_mode(input logic [12:0] mode);
    logic [12:0] fixed;
    fixed = mode;
    if (!cl_legal(mode[6:4])) fixed[6:4] = CL_SAFE;
    return fixed;
  endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Shared wait down-counter: load N-1 on state entry, stops at zero.
module sdram_wait_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialization: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, then DONE. All outputs are registered.
//
// state        | meaning
// PWR_WAIT     | NOP with cke=1 for POWERUP_CYCLES after reset release
// PRECHARGE    | one-cycle PRECHARGE ALL (addr[10]=1)
// TRP_WAIT     | NOP gap after PRECHARGE
// AREF         | one-cycle AUTO REFRESH
// TRFC_WAIT    | NOP gap after AUTO REFRESH
// LMR          | one-cycle LOAD MODE with the (sanitised) mode word
// TMRD_WAIT    | NOP gap after LOAD MODE
// DONE         | NOP, init_done=1, reinit restarts from PRECHARGE
module sdram_init_seq
  import sdram_init_pkg::*;
#(
  parameter int POWERUP_CYCLES = DEF_POWERUP_CYCLES,
  parameter int TRP            = DEF_TRP,
  parameter int TRFC           = DEF_TRFC,
  parameter int TMRD           = DEF_TMRD,
  parameter int NUM_REFRESH    = DEF_NUM_REFRESH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] cfg_mode_reg,
  input  logic        reinit,
  output logic        sdr_cke,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        init_done,
  output logic        cfg_err
);

  // A wait state of N cycles loads N-1; the gap after a command of spacing T
  // is T-1 cycles long, hence T-2.
  localparam logic [15:0] PWR_LOAD  = 16'(POWERUP_CYCLES - 1);
  localparam logic [15:0] TRP_LOAD  = 16'(TRP - 2);
  localparam logic [15:0] TRFC_LOAD = 16'(TRFC - 2);
  localparam logic [15:0] TMRD_LOAD = 16'(TMRD - 2);
  localparam logic [3:0]  REF_LOAD  = 4'(NUM_REFRESH);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [3:0]  ref_q, ref_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cke_q;

  logic        cnt_load;
  logic [15:0] cnt_val;
  logic        cnt_zero;

  sdram_wait_cnt #(.W(16)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  // Next state, wait-counter loads, and next-cycle outputs decoded from state_d.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    ref_d    = ref_q;
    err_d    = err_q;
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    ba_d     = '0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;

    // start_q marks the first cycle out of reset: that edge is PWR_WAIT entry.
    if (start_q) begin
      state_d  = ST_PWR_WAIT;
      cnt_load = 1'b1;
      cnt_val  = PWR_LOAD;
    end else begin
      unique case (state_q)
        ST_PWR_WAIT:  if (cnt_zero) state_d = ST_PRECHARGE;
        ST_PRECHARGE: begin
          state_d  = ST_TRP_WAIT;
          cnt_load = 1'b1;
          cnt_val  = TRP_LOAD;
        end
        ST_TRP_WAIT:  if (cnt_zero) state_d = ST_AREF;
        ST_AREF: begin
          state_d  = ST_TRFC_WAIT;
          cnt_load = 1'b1;
          cnt_val  = TRFC_LOAD;
        end
        ST_TRFC_WAIT: if (cnt_zero) state_d = (ref_q == 4'd0) ? ST_LMR : ST_AREF;
        ST_LMR: begin
          state_d  = ST_TMRD_WAIT;
          cnt_load = 1'b1;
          cnt_val  = TMRD_LOAD;
        end
        ST_TMRD_WAIT: if (cnt_zero) state_d = ST_DONE;
        ST_DONE:      if (reinit) state_d = ST_PRECHARGE;
        default:      state_d = ST_PWR_WAIT;
      endcase
    end

    unique case (state_d)
      ST_PRECHARGE: begin
        cmd_d      = CMD_PRECHARGE;
        addr_d[10] = 1'b1;
        ref_d      = REF_LOAD;
      end
      ST_AREF: begin
        cmd_d = CMD_AREF;
        ref_d = ref_q - 4'd1;
      end
      ST_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = fix_mode(cfg_mode_reg);
        if (!cl_legal(cfg_mode_reg[6:4])) err_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: cmd_d = CMD_NOP;
    endcase
  end

  // FSM and output registers; reset forces DESELECT with the clock disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PWR_WAIT;
      start_q <= 1'b1;
      ref_q   <= '0;
      cmd_q   <= CMD_DESELECT;
      cke_q   <= 1'b0;
      addr_q  <= '0;
      ba_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      cke_q   <= 1'b1;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_cke   = cke_q;
  assign sdr_addr  = addr_q;
  assign sdr_ba    = ba_q;
  assign init_done = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: expected command events are queued when
// a sequence is started and popped as the DUT issues non-NOP commands.
module tb_sdram_init_seq;

  localparam int PWR  = 10000;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TMRD = 2;
  localparam int NREF = 8;

  localparam logic [3:0] E_DESEL = 4'b1111;
  localparam logic [3:0] E_NOP   = 4'b0111;
  localparam logic [3:0] E_PRE   = 4'b0010;
  localparam logic [3:0] E_AREF  = 4'b0001;
  localparam logic [3:0] E_LMR   = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] cfg_mode_reg = 13'h037;
  logic        reinit = 1'b0;
  logic        sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        init_done, cfg_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        err;
  } ev_t;

  ev_t q[$];

  sdram_init_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_mode_reg (cfg_mode_reg),
    .reinit       (reinit),
    .sdr_cke      (sdr_cke),
    .sdr_cs_n     (sdr_cs_n),
    .sdr_ras_n    (sdr_ras_n),
    .sdr_cas_n    (sdr_cas_n),
    .sdr_we_n     (sdr_we_n),
    .sdr_addr     (sdr_addr),
    .sdr_ba       (sdr_ba),
    .init_done    (init_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the command events of one init pass whose PRECHARGE is at cycle
  // 'start'; returns the cycle where init_done is first expected high.
  function automatic int push_init(input int start, input logic [12:0] mode, input logic err);
    int c;
    c = start;
    q.push_back('{tag: "PRE", cyc: c, cmd: E_PRE, addr: 13'h400, err: 1'b0});
    c += TRP;
    for (int i = 0; i < NREF; i++) begin
      q.push_back('{tag: $sformatf("AREF%0d", i + 1), cyc: c, cmd: E_AREF, addr: 13'h000, err: 1'b0});
      c += TRFC;
    end
    q.push_back('{tag: "LMR", cyc: c, cmd: E_LMR, addr: mode, err: err});
    return c + TMRD;
  endfunction

  // Hold reset for n cycles, checking the reset outputs each cycle.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_cmd", {28'd0, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, {28'd0, E_DESEL});
      chk("rst_cke", {31'd0, sdr_cke}, 32'd0);
      chk("rst_addr_ba", {17'd0, sdr_addr, sdr_ba}, 32'd0);
      chk("rst_done_err", {30'd0, init_done, cfg_err}, 32'd0);
    end
    rst = 1'b0;
  endtask

  // Watch ncyc cycles; reinit is held high for the first 'hold' edges.
  task automatic watch(input int ncyc, input int hold, output int done_first);
    logic [3:0] cmd;
    logic       cke_bad;
    ev_t        e;
    cke_bad    = 1'b0;
    done_first = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      reinit = (k < hold);
      cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
      if (sdr_cke !== 1'b1) cke_bad = 1'b1;
      if (init_done === 1'b1 && done_first < 0) done_first = k;
      if (cmd !== E_NOP) begin
        if (q.size() == 0) begin
          chk($sformatf("extra_cmd@%0d", k), {28'd0, cmd}, {28'd0, E_NOP});
        end else begin
          e = q.pop_front();
          chk($sformatf("%s_cycle", e.tag), k, e.cyc);
          chk($sformatf("%s_cmd", e.tag), {28'd0, cmd}, {28'd0, e.cmd});
          chk($sformatf("%s_addr", e.tag), {19'd0, sdr_addr}, {19'd0, e.addr});
          chk($sformatf("%s_ba", e.tag), {30'd0, sdr_ba}, 32'd0);
          if (e.cmd == E_LMR) chk("LMR_cfg_err", {31'd0, cfg_err}, {31'd0, e.err});
        end
      end
    end
    chk("cke_high", {31'd0, cke_bad}, 32'd0);
  endtask

  initial begin
    int d, df;

    // Power-up with a legal mode word (full page, CL=3)
    cfg_mode_reg = 13'h037;
    do_reset(3);
    d = push_init(PWR + 1, 13'h037, 1'b0);
    watch(d + 3, 0, df);
    chk("done_cycle_pwrup", df, d);
    chk("queue_empty_pwrup", q.size(), 0);

    // Reinit with CL=4: forced to CL=3, error flag sets
    cfg_mode_reg = 13'h047;
    reinit = 1'b1;
    d = push_init(1, 13'h037, 1'b1);
    watch(d + 3, 1, df);
    chk("done_cycle_reinit_cl4", df, d);
    chk("queue_empty_reinit_cl4", q.size(), 0);
    chk("cfg_err_set", {31'd0, cfg_err}, 32'd1);

    // Reinit with a legal mode word: error flag is retained
    cfg_mode_reg = 13'h037;
    reinit = 1'b1;
    d = push_init(1, 13'h037, 1'b1);
    watch(d + 3, 1, df);
    chk("done_cycle_reinit2", df, d);
    chk("queue_empty_reinit2", q.size(), 0);

    // Reset clears the error; abort during the 4th TRFC gap
    do_reset(2);
    d = push_init(PWR + 1, 13'h037, 1'b0);
    watch(PWR + 1 + TRP + 3 * TRFC + 2, 0, df);
    chk("abort_no_done", df, -1);
    chk("abort_events_left", q.size(), 5);
    q.delete();
    do_reset(1);
    d = push_init(PWR + 1, 13'h037, 1'b0);
    watch(d + 3, 0, df);
    chk("done_cycle_after_abort", df, d);
    chk("queue_empty_after_abort", q.size(), 0);

    // rst and reinit together, then reinit held through most of PWR_WAIT
    cfg_mode_reg = 13'h022;
    reinit = 1'b1;
    do_reset(2);
    d = push_init(PWR + 1, 13'h022, 1'b0);
    watch(d + 3, 5000, df);
    chk("done_cycle_reinit_held", df, d);
    chk("queue_empty_reinit_held", q.size(), 0);
    chk("cfg_err_clear_cl2", {31'd0, cfg_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
